// File: rtl/freq_meter_ctrl_if.sv
// Control and result bundle between the gate-time sequencer and its BCD decade counter / reader.
interface freq_meter_ctrl_if;
  logic        run;
  logic [15:0] count_in;
  logic        cnt_enable;
  logic        cnt_reset_n;
  logic [15:0] freq_out;
  logic        ovf_out;
  logic        valid;
  logic        busy;

  modport master (
    input  run, count_in,
    output cnt_enable, cnt_reset_n, freq_out, ovf_out, valid, busy
  );

  modport slave (
    output run, count_in,
    input  cnt_enable, cnt_reset_n, freq_out, ovf_out, valid, busy
  );
endinterface

// File: rtl/freq_meter_ctrl.sv
// Gate-time sequencer: clear -> arm -> gate -> settle -> latch of a 4-digit BCD counter.
// Latency: valid rises CLR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+2 cycles after run is sampled.
// No backpressure: run is a level, sampled only in IDLE and at the end of LATCH.
module freq_meter_ctrl #(
  parameter int GATE_CYCLES   = 1000,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = 16
) (
  input  logic              clk,
  input  logic              reset,
  freq_meter_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_GATE   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_LATCH  = 3'd5;

  localparam logic [CW-1:0] CLR_LOAD    = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] GATE_LOAD   = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_load;
  logic          ovf_flag;
  logic [3:0]    prev_digit;
  logic          cyc_done;

  assign cyc_done = (cyc == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.run) state_nxt = S_CLEAR;
      S_CLEAR:  if (cyc_done) state_nxt = S_ARM;
      S_ARM:    state_nxt = S_GATE;
      S_GATE:   if (cyc_done) state_nxt = S_SETTLE;
      S_SETTLE: if (cyc_done) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = bus.run ? S_CLEAR : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Count down from (length-1) so the state exits on the cycle the counter reads zero.
  always_comb begin
    cyc_load = '0;
    case (state_nxt)
      S_CLEAR:  cyc_load = CLR_LOAD;
      S_GATE:   cyc_load = GATE_LOAD;
      S_SETTLE: cyc_load = SETTLE_LOAD;
      default:  cyc_load = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cyc <= cyc_load;
      end else if (!cyc_done) begin
        cyc <= cyc - CW'(1);
      end
    end
  end

  // A wrap of the top digit from 9 to 0 while the counter may still move means the gate saw > 9999 edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag   <= 1'b0;
      prev_digit <= 4'h0;
    end else if (state == S_CLEAR) begin
      ovf_flag   <= 1'b0;
      prev_digit <= 4'h0;
    end else if (state == S_GATE || state == S_SETTLE) begin
      prev_digit <= bus.count_in[15:12];
      if (prev_digit == 4'h9 && bus.count_in[15:12] == 4'h0) begin
        ovf_flag <= 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cnt_enable  <= 1'b0;
      bus.cnt_reset_n <= 1'b0;
      bus.busy        <= 1'b0;
      bus.valid       <= 1'b0;
      bus.freq_out    <= 16'h0000;
      bus.ovf_out     <= 1'b0;
    end else begin
      bus.cnt_enable  <= (state_nxt == S_GATE);
      bus.cnt_reset_n <= !(state_nxt == S_IDLE || state_nxt == S_CLEAR);
      bus.busy        <= (state_nxt != S_IDLE);
      bus.valid       <= (state == S_LATCH);
      if (state == S_LATCH) begin
        bus.freq_out <= bus.count_in;
        bus.ovf_out  <= ovf_flag;
      end
    end
  end

endmodule
